modn_cascade_counter: RTL
=========================

# modn_cascade_counter

Parametrised modulo-N counter stage for the clock/timer chain: it counts `tick_in` pulses modulo `MODULUS` in either direction and emits a carry/borrow pulse on `tick_out` to the next stage. It supports synchronous load with range checking and a freeze control. Stages chain `tick_out -> tick_in` to build seconds/minutes/hours timers of any radix. The whole chain ripples within a single clock cycle.

## Interface
- `MODULUS`, 60, count range 0..MODULUS-1; must be ≥2.
- `WIDTH`, 6, counter width; must satisfy 2^WIDTH ≥ MODULUS.
- `RESET_VALUE`, 0, value loaded on reset; must be < MODULUS.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_in`  in  1  count-enable pulse from the previous stage (one cycle per count).
- `up_down`  in  1  1 = count up, 0 = count down.
- `load`  in  1  synchronous load strobe.
- `load_value`  in  WIDTH  value to load.
- `freeze`  in  1  hold count and suppress `tick_out`.
- `count`  out  WIDTH  registered count value.
- `tick_out`  out  1  combinational carry/borrow pulse to the next stage.
- `load_err`  out  1  registered sticky flag, set by an out-of-range load.
- `bcd_tens`, `bcd_units`  out  4 each  registered BCD of `count` (only with `MODN_BCD_OUT_EN`).

## Operation
- Per-edge priority: reset > load > freeze > tick_in > hold.
- **Reset (async):**
  - `count` = RESET_VALUE.
  - `load_err` = 0.
  - BCD outputs = BCD of RESET_VALUE.
  - `tick_out` = 0 while reset is asserted.
- **Load:**
  - If `load_value` < MODULUS: `count` <= `load_value`, `load_err` <= 0.
  - Otherwise: `count` holds, `load_err` <= 1.
  - `tick_in` is ignored in a load cycle; `tick_out` = 0.
- **Freeze (no load):** `count` holds; `tick_out` = 0; `tick_in` is dropped, not queued.
- **Count (tick_in=1, no load/freeze):**
  - Up: `count` == MODULUS-1 -> 0, else +1.
  - Down: `count` == 0 -> MODULUS-1, else -1.
- **tick_out:** = `tick_in & ~load & ~freeze & ~reset & (up_down ? count==MODULUS-1 : count==0)`.
  - Asserts exactly on the tick that wraps; never merely because `count` sits at its terminal value.
- **Defensive recovery:** if `count` ≥ MODULUS (not reachable in normal operation), the next counting tick sets `count` to 0 in either direction, with no `tick_out`.
- **`load_err`:** sticky across counting and freeze; cleared only by reset or a valid load.
- **Direction:** `up_down` may change on any cycle; it is sampled together with `tick_in`.
- **Arithmetic:** all in WIDTH bits; wrap is by explicit compare, never by natural overflow. This holds for non-power-of-two MODULUS.

## Timing
- `count` updates on the clock edge after `tick_in`/`load` is sampled high (latency 1).
- `tick_out` is combinational from the current `count` and inputs, so an N-stage chain wraps on a single edge. The ripple path is the limiting timing path.
- `load_err` updates on the same edge as the load.
- BCD outputs lag `count` by one cycle.
- Reset deassertion: first count occurs on the first edge with `tick_in`=1 after reset falls.
- Reset mid-operation: `count` goes to RESET_VALUE immediately; in-flight ticks are lost.

## Configuration
- `MODN_BCD_OUT_EN` defined:
  - `bcd_tens`/`bcd_units` ports exist, registered from `count` (tens = count/10, units = count%10).
  - Requires MODULUS ≤ 100.
- Not defined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- **Up wrap:** MODULUS=60, reset, 59 ticks up -> `count`=59, `tick_out`=0 while idle. 60th tick -> `tick_out`=1 that cycle, `count`=0 next edge.
- **Down wrap:** from 0, `up_down`=0, 1 tick -> `tick_out`=1, `count`=59. Next tick -> 58, `tick_out`=0.
- **Load:**
  - `load_value`=45 -> `count`=45, `load_err`=0.
  - `load_value`=60 -> `count` stays 45, `load_err`=1, flag persists through 3 ticks (count reaches 48).
  - Next `load_value`=10 -> `load_err`=0.
- **Simultaneous events:**
  - `count`=59, `tick_in`+`load`(5) -> `count`=5, `tick_out`=0.
  - `count`=59, `tick_in`+`freeze` -> `count`=59, `tick_out`=0.
- **Cascade:** three stages with MODULUS 60/60/24, all at terminal count, one tick -> all three wrap to 0 on one edge.
- **Async reset and BCD:**
  - Reset asserted mid-count at 37 (no clock edge) -> `count`=RESET_VALUE immediately.
  - With `MODN_BCD_OUT_EN` and `count`=47 -> tens=4, units=7 one cycle later.

Source files
------------

// File: rtl/modn_cascade_counter_if.sv
// Bus bundle for one modulo-N counter stage; the counter takes the slave side.
// BCD outputs are present only when MODN_BCD_OUT_EN is defined.
interface modn_cascade_counter_if #(
    parameter int WIDTH = 6
);
    logic             tick_in;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             freeze;
    logic [WIDTH-1:0] count;
    logic             tick_out;
    logic             load_err;
`ifdef MODN_BCD_OUT_EN
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_units;

    modport master (output tick_in, up_down, load, load_value, freeze,
                    input  count, tick_out, load_err, bcd_tens, bcd_units);
    modport slave  (input  tick_in, up_down, load, load_value, freeze,
                    output count, tick_out, load_err, bcd_tens, bcd_units);
`else
    modport master (output tick_in, up_down, load, load_value, freeze,
                    input  count, tick_out, load_err);
    modport slave  (input  tick_in, up_down, load, load_value, freeze,
                    output count, tick_out, load_err);
`endif
endinterface

// File: rtl/modn_cascade_counter.sv
// Up/down modulo-MODULUS counter stage with combinational carry/borrow for chaining.
// Define MODN_BCD_OUT_EN to add registered BCD tens/units of the count.
module modn_cascade_counter #(
    parameter int MODULUS     = 60,
    parameter int WIDTH       = 6,
    parameter int RESET_VALUE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    modn_cascade_counter_if.slave   bus
);
    localparam logic [WIDTH:0]   MOD_C = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             at_term;
    logic             cnt_in_range;
    logic             ld_in_range;

    // Out-of-range count never matches a terminal value, so it never carries.
    assign at_term      = bus.up_down ? (count_q == MAX_C) : (count_q == '0);
    assign cnt_in_range = {1'b0, count_q} < MOD_C;
    assign ld_in_range  = {1'b0, bus.load_value} < MOD_C;

    assign bus.tick_out = bus.tick_in & ~bus.load & ~bus.freeze & ~reset & at_term;
    assign bus.count    = count_q;
    assign bus.load_err = err_q;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (bus.load) begin
            if (ld_in_range) begin
                count_d = bus.load_value;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (!bus.freeze && bus.tick_in) begin
            // Wrap by explicit compare so non-power-of-two moduli work.
            if (!cnt_in_range)
                count_d = '0;
            else if (bus.up_down)
                count_d = (count_q == MAX_C) ? '0 : count_q + 1'b1;
            else
                count_d = (count_q == '0) ? MAX_C : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RST_C;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef MODN_BCD_OUT_EN
    localparam logic [3:0] RST_TENS  = 4'(RESET_VALUE / 10);
    localparam logic [3:0] RST_UNITS = 4'(RESET_VALUE % 10);

    logic [WIDTH+3:0] count_w;
    logic [3:0]       tens_q, units_q;

    // Widened so the divisor 10 is representable for any WIDTH.
    assign count_w = (WIDTH+4)'(count_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= RST_TENS;
            units_q <= RST_UNITS;
        end else begin
            tens_q  <= 4'(count_w / (WIDTH+4)'(10));
            units_q <= 4'(count_w % (WIDTH+4)'(10));
        end
    end

    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_units = units_q;
`endif
endmodule
